// File: rtl/truth_table_checker.sv
// Exhaustive 3-input response checker: drives {z,x,y}=0..7, samples dut_out, compares to EXPECTED.
// Latency: start at edge N -> done after edge N+8*HOLD; each vector held HOLD cycles.
// No backpressure: start is accepted in IDLE/DONE only and ignored while busy.
module truth_table_checker #(
  parameter int          HOLD     = 4,
  parameter logic [7:0]  EXPECTED = 8'hE8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [3:0] mismatch_cnt
);

  localparam int HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [7:0] GOLDEN = EXPECTED;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [2:0]    r_vec;
  logic [HW-1:0] r_hold;
  logic [7:0]    r_captured;
  logic [3:0]    r_mis;

  logic w_sample;
  logic w_exp_bit;
  logic w_last_vec;

  // Sample strobe fires on the final cycle a vector is held.
  always_comb begin
    w_sample   = (r_state == S_DRIVE) && (r_hold == HOLD_LAST);
    w_exp_bit  = GOLDEN[r_vec];
    w_last_vec = (r_vec == 3'd7);
  end

  // Sequencer: steps through vectors, captures responses, counts mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_vec      <= 3'd0;
      r_hold     <= '0;
      r_captured <= 8'h00;
      r_mis      <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_DRIVE;
            r_vec      <= 3'd0;
            r_hold     <= '0;
            r_captured <= 8'h00;
            r_mis      <= 4'd0;
          end
        end
        S_DRIVE: begin
          if (w_sample) begin
            r_captured[r_vec] <= dut_out;
            if (dut_out != w_exp_bit) begin
              r_mis <= r_mis + 4'd1;
            end
            if (w_last_vec) begin
              // Index stays at 7 so the final vector remains visible in DONE.
              r_state <= S_DONE;
              r_hold  <= '0;
            end else begin
              r_vec  <= r_vec + 3'd1;
              r_hold <= '0;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode; DUT inputs come straight from the registered index.
  always_comb begin
    vec_idx      = r_vec;
    z            = r_vec[2];
    x            = r_vec[1];
    y            = r_vec[0];
    busy         = (r_state == S_DRIVE);
    done         = (r_state == S_DONE);
    pass         = (r_state == S_DONE) && (r_mis == 4'd0);
    captured     = r_captured;
    mismatch_cnt = r_mis;
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker with HOLD=4, EXPECTED=8'hE8.
// Directed sequence plus random truth tables; a table-driven DUT stands in for the gate network.
// Expected results come from popcount arithmetic on the chosen table.
module tb_truth_table_checker;

  localparam int         HOLD     = 4;
  localparam logic [7:0] EXPECTED = 8'hE8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dut_out;
  logic       x, y, z;
  logic [2:0] vec_idx;
  logic       busy, done, pass;
  logic [7:0] captured;
  logic [3:0] mismatch_cnt;

  logic [7:0] dut_tbl = 8'h00;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // Stand-in combinational DUT: looks up its response from the pins it sees.
  assign dut_out = dut_tbl[{z, x, y}];

  truth_table_checker #(.HOLD(HOLD), .EXPECTED(EXPECTED)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .x(x), .y(y), .z(z), .vec_idx(vec_idx),
    .busy(busy), .done(done), .pass(pass),
    .captured(captured), .mismatch_cnt(mismatch_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tbl_majority();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      t[i] = ((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1)) >= 2;
    end
    return t;
  endfunction

  function automatic logic [7:0] tbl_and3();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = (i == 7);
    return t;
  endfunction

  // Full run: pulse start, walk all 8*HOLD drive cycles, check final results.
  // If inject is set, a stray start is pulsed while vector 3 is driven.
  task automatic run(input string name, input logic [7:0] tbl, input bit inject);
    logic [7:0] exp_cap;
    int         exp_mis;
    dut_tbl = tbl;
    exp_cap = tbl;
    exp_mis = $countones(tbl ^ EXPECTED);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_clr_cap"}, 32'(captured), 32'h0);
    check({name, "_clr_mis"}, 32'(mismatch_cnt), 32'h0);
    for (int i = 0; i < 8; i++) begin
      for (int h = 0; h < HOLD; h++) begin
        check({name, "_vec"}, 32'(vec_idx), 32'(i));
        check({name, "_zxy"}, 32'({z, x, y}), 32'(i));
        check({name, "_busy"}, 32'(busy), 32'h1);
        check({name, "_done_lo"}, 32'(done), 32'h0);
        start = inject && (i == 3) && (h == 1);
        tick();
        start = 1'b0;
      end
    end
    check({name, "_done"}, 32'(done), 32'h1);
    check({name, "_busy_lo"}, 32'(busy), 32'h0);
    check({name, "_cap"}, 32'(captured), 32'(exp_cap));
    check({name, "_mis"}, 32'(mismatch_cnt), 32'(exp_mis));
    check({name, "_pass"}, 32'(pass), 32'(exp_mis == 0));
    check({name, "_vec_end"}, 32'(vec_idx), 32'h7);
    // Results stay frozen while idling in DONE.
    tick(); tick();
    check({name, "_hold_cap"}, 32'(captured), 32'(exp_cap));
    check({name, "_hold_done"}, 32'(done), 32'h1);
  endtask

  task automatic check_idle(input string name);
    check({name, "_zxy"}, 32'({z, x, y}), 32'h0);
    check({name, "_vec"}, 32'(vec_idx), 32'h0);
    check({name, "_busy"}, 32'(busy), 32'h0);
    check({name, "_done"}, 32'(done), 32'h0);
    check({name, "_pass"}, 32'(pass), 32'h0);
    check({name, "_cap"}, 32'(captured), 32'h0);
    check({name, "_mis"}, 32'(mismatch_cnt), 32'h0);
  endtask

  initial begin
    // 1. reset, then idle five cycles
    rst = 1'b1;
    dut_tbl = 8'hFF;
    tick(); tick();
    rst = 1'b0;
    check_idle("reset");
    for (int k = 0; k < 5; k++) tick();
    check_idle("idle5");

    // 2. majority gate matches the golden table
    run("maj", tbl_majority(), 1'b0);

    // 3 + 4. three-input AND, with a stray start mid-run
    run("and3", tbl_and3(), 1'b1);

    // 5. reset while vector 5 is driven
    dut_tbl = tbl_majority();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5 * HOLD + 1; k++) tick();
    check("midrst_vec5", 32'(vec_idx), 32'h5);
    check("midrst_partial", 32'(captured), 32'(tbl_majority() & 8'h1F));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    tick();
    check_idle("midrst_after");
    run("clean", tbl_majority(), 1'b0);

    // 6. restart from DONE with constant-1 DUT
    run("const1", 8'hFF, 1'b0);

    // random truth tables
    for (int r = 0; r < 4; r++) begin
      run($sformatf("rnd%0d", r), 8'($urandom_range(0, 255)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
